// File: rtl/sdp_ram_pipe.sv
// Simple dual-port single-clock RAM with per-lane write enables, optional output
// register, selectable read-during-write behaviour and a post-reset clear sequencer.
module sdp_ram_pipe #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int BYTE_WIDTH     = 8,
  parameter int OUT_REG        = 0,
  parameter int FWD            = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    wByteEn,
  input  logic [ADDR_WIDTH-1:0]               writeAddr,
  input  logic [DATA_WIDTH-1:0]               dataIn,
  input  logic                                en,
  input  logic [ADDR_WIDTH-1:0]               readAddr,
  output logic [DATA_WIDTH-1:0]               dataOut,
  output logic                                dataValid,
  output logic                                busy
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Replace the enabled lanes of old_word with the matching lanes of new_word.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         lane_en
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++) begin
      if (lane_en[i]) begin
        res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
      end else begin
        res[i*BYTE_WIDTH +: BYTE_WIDTH] = old_word[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  state_t                state_r;
  state_t                state_next_s;
  logic [ADDR_WIDTH-1:0] clr_cnt_r;
  logic [ADDR_WIDTH-1:0] clr_cnt_next_s;
  logic                  busy_r;

  logic [NB-1:0]         mem_lane_we_s;
  logic [ADDR_WIDTH-1:0] mem_addr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic                  user_wr_s;
  logic                  user_rd_s;
  logic [DATA_WIDTH-1:0] old_word_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  logic [DATA_WIDTH-1:0] s1_data_r;
  logic                  s1_valid_r;

  // Next-state, clear-write and request-qualification logic.
  always_comb begin
    state_next_s   = state_r;
    clr_cnt_next_s = clr_cnt_r;
    mem_lane_we_s  = {NB{1'b0}};
    mem_addr_s     = writeAddr;
    mem_wdata_s    = dataIn;
    user_wr_s      = 1'b0;
    user_rd_s      = 1'b0;
    if (reset) begin
      state_next_s   = CLEAR;
      clr_cnt_next_s = {ADDR_WIDTH{1'b0}};
    end else begin
      case (state_r)
        CLEAR: begin
          if (CLEAR_ON_RESET != 0) begin
            mem_lane_we_s  = {NB{1'b1}};
            mem_addr_s     = clr_cnt_r;
            mem_wdata_s    = {DATA_WIDTH{1'b0}};
            clr_cnt_next_s = clr_cnt_r + ADDR_WIDTH'(1);
            if (clr_cnt_r == LAST_ADDR) begin
              state_next_s = READY;
            end else begin
              state_next_s = CLEAR;
            end
          end else begin
            state_next_s = READY;
          end
        end
        READY: begin
          user_wr_s     = we && (wByteEn != {NB{1'b0}});
          user_rd_s     = en;
          mem_lane_we_s = we ? wByteEn : {NB{1'b0}};
        end
        default: begin
          state_next_s = CLEAR;
        end
      endcase
    end
  end

  // Read word, with the in-flight write merged in on a same-address collision when forwarding.
  always_comb begin
    old_word_s = mem_r[readAddr];
    if ((FWD != 0) && user_wr_s && (writeAddr == readAddr)) begin
      rd_word_s = merge_lanes(old_word_s, dataIn, wByteEn);
    end else begin
      rd_word_s = old_word_s;
    end
  end

  // Control state, clear counter and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= CLEAR;
      clr_cnt_r <= {ADDR_WIDTH{1'b0}};
      busy_r    <= 1'b1;
    end else begin
      state_r   <= state_next_s;
      clr_cnt_r <= clr_cnt_next_s;
      busy_r    <= (state_next_s == CLEAR);
    end
  end

  // Array write port; reset leaves the contents alone, the clear sequencer zeroes them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_lane_we_s[i]) begin
        mem_r[mem_addr_s][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata_s[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // First read stage: data holds between reads, valid follows the accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_data_r  <= {DATA_WIDTH{1'b0}};
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= user_rd_s;
      if (user_rd_s) begin
        s1_data_r <= rd_word_s;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] s2_data_r;
      logic                  s2_valid_r;

      // Second read stage adds one cycle of latency.
      always_ff @(posedge clk) begin
        if (reset) begin
          s2_data_r  <= {DATA_WIDTH{1'b0}};
          s2_valid_r <= 1'b0;
        end else begin
          s2_valid_r <= s1_valid_r;
          if (s1_valid_r) begin
            s2_data_r <= s1_data_r;
          end
        end
      end

      assign dataOut   = s2_data_r;
      assign dataValid = s2_valid_r;
    end else begin : g_no_out_reg
      assign dataOut   = s1_data_r;
      assign dataValid = s1_valid_r;
    end
  endgenerate

  assign busy = busy_r;

endmodule
